// File: rtl/pdm_modulator.sv
// First-order sigma-delta PDM modulator: buffers one signed PCM sample over valid/ready
// and emits a 1-bit PDM stream plus its bit clock, with selectable data-change edge.
`timescale 1ns/1ps
module pdm_modulator #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned CLK_DIV = 32,
    parameter int unsigned OSR     = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             lr,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_valid,
    output logic             sample_ready,
    output logic             pdm_clk,
    output logic             pdm_out,
    output logic             underrun
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W = (OSR > 1) ? $clog2(OSR) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(OSR - 1);

    logic [DIV_W-1:0] r_div_cnt;
    logic [BIT_W-1:0] r_bit_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_active;
    logic [WIDTH-1:0] r_hold;
    logic             r_full;
    logic             r_lr_q;
    logic             r_pdm_clk;
    logic             r_pdm_out;
    logic             r_underrun;

    logic             w_rise;
    logic             w_fall;
    logic             w_step;
    logic             w_bnd;
    logic             w_take;
    logic [WIDTH-1:0] w_u;
    logic [WIDTH:0]   w_sum;

    // Event decode: lr picks the rising edge directly; falling steps use the lr latched
    // at the previous rising event so each period gets exactly one step.
    always_comb begin
        w_rise = en && (r_div_cnt == DIV_LAST);
        w_fall = en && (r_div_cnt == DIV_HALF);
        w_step = (w_rise && lr) || (w_fall && !r_lr_q);
        w_bnd  = w_step && (r_bit_cnt == BIT_LAST);
        w_take = sample_valid && !r_full;
        w_u    = {~r_active[WIDTH-1], r_active[WIDTH-2:0]};
        w_sum  = {1'b0, r_acc} + {1'b0, w_u};
    end

    assign sample_ready = reset && !r_full;
    assign pdm_clk      = r_pdm_clk;
    assign pdm_out      = r_pdm_out;
    assign underrun     = r_underrun;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_acc      <= '0;
            r_active   <= '0;
            r_hold     <= '0;
            r_full     <= 1'b0;
            r_lr_q     <= 1'b0;
            r_pdm_clk  <= 1'b0;
            r_pdm_out  <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            if (w_take) begin
                r_hold <= sample_in;
                r_full <= 1'b1;
            end
            if (!en) begin
                r_div_cnt <= '0;
                r_bit_cnt <= '0;
                r_acc     <= '0;
                r_pdm_clk <= 1'b0;
                r_pdm_out <= 1'b0;
            end else begin
                r_div_cnt <= w_rise ? '0 : r_div_cnt + DIV_W'(1);
                if (w_rise) begin
                    r_pdm_clk <= 1'b1;
                    r_lr_q    <= lr;
                end
                if (w_fall) begin
                    r_pdm_clk <= 1'b0;
                end
                if (w_step) begin
                    r_pdm_out <= w_sum[WIDTH];
                    r_acc     <= w_sum[WIDTH-1:0];
                    r_bit_cnt <= (r_bit_cnt == BIT_LAST) ? '0 : r_bit_cnt + BIT_W'(1);
                    // Boundary: swap in the buffered sample, or flag that none arrived
                    if (w_bnd) begin
                        if (r_full) begin
                            r_active <= r_hold;
                            r_full   <= 1'b0;
                        end else begin
                            r_underrun <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule
